// File: rtl/sys_ctrl_burst.sv
// Command controller: decodes RX command frames, sequences register-file and ALU
// transactions, and serialises results into TX FIFO pushes under backpressure.
module sys_ctrl_burst #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUN_W  = 4,
  parameter int unsigned RES_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_d_valid,
  input  logic [DATA_W-1:0] i_rx_p_data,
  input  logic              i_rd_d_valid,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_alu_valid,
  input  logic [RES_W-1:0]  i_alu_out,
  input  logic              i_full,
  output logic              o_alu_en,
  output logic              o_clk_en,
  output logic              o_wr_en,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [FUN_W-1:0]  o_alu_fun,
  output logic              o_wr_inc,
  output logic [DATA_W-1:0] o_fifo_p_data,
  output logic              o_err
);

  localparam int unsigned RES_BYTES = RES_W / DATA_W;
  localparam int unsigned BL_W      = $clog2(RES_BYTES + 1);

  localparam logic [DATA_W-1:0] OpWr  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OpRd  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OpAlu = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OpFun = DATA_W'(8'hDD);
  localparam logic [DATA_W-1:0] OpBw  = DATA_W'(8'hEE);
  localparam logic [DATA_W-1:0] OpBr  = DATA_W'(8'hEF);

  typedef enum logic [4:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StAluA, StAluB, StAluFun, StAluGate,
    StAluWait, StBwAddr, StBwCnt, StBwData, StBrAddr, StBrCnt, StBrIssue, StBrWait, StPush
  } state_e;

  state_e            r_state;
  logic              r_alu_en;
  logic              r_clk_en;
  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_wr_data;
  logic [FUN_W-1:0]  r_alu_fun;
  logic [DATA_W-1:0] r_cnt;
  logic [BL_W-1:0]   r_bytes_left;
  logic [RES_W-1:0]  r_res;
  logic              r_push_pend;

  logic              w_busy;
  logic              w_push_done;

  // States that cannot take a new byte; a strobe here is dropped and flagged.
  assign w_busy = r_state inside {StRdWait, StAluGate, StAluWait, StBrIssue, StBrWait, StPush};
  assign w_push_done = r_push_pend & ~i_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_alu_en     <= 1'b0;
      r_clk_en     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_ptr        <= '0;
      r_wr_data    <= '0;
      r_alu_fun    <= '0;
      r_cnt        <= '0;
      r_bytes_left <= '0;
      r_res        <= '0;
      r_push_pend  <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_err    <= i_rx_d_valid & w_busy;
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (i_rx_d_valid) begin
            case (i_rx_p_data)
              OpWr:    r_state <= StWrAddr;
              OpRd:    r_state <= StRdAddr;
              OpAlu:   r_state <= StAluA;
              OpFun:   r_state <= StAluFun;
              OpBw:    r_state <= StBwAddr;
              OpBr:    r_state <= StBrAddr;
              default: r_err   <= 1'b1;
            endcase
          end
        end
        StWrAddr: if (i_rx_d_valid) begin
          r_addr  <= i_rx_p_data[ADDR_W-1:0];
          r_state <= StWrData;
        end
        StWrData: if (i_rx_d_valid) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= i_rx_p_data;
          r_state   <= StIdle;
        end
        StRdAddr: if (i_rx_d_valid) begin
          r_addr  <= i_rx_p_data[ADDR_W-1:0];
          r_rd_en <= 1'b1;
          r_state <= StRdWait;
        end
        StRdWait, StBrIssue, StBrWait: begin
          if (i_rd_d_valid) begin
            r_res        <= RES_W'(i_rd_data);
            r_bytes_left <= BL_W'(1);
            r_push_pend  <= 1'b1;
            r_state      <= StPush;
          end else if (r_state == StBrIssue) begin
            r_state <= StBrWait;
          end
        end
        StAluA: if (i_rx_d_valid) begin
          r_addr    <= ADDR_W'(0);
          r_wr_data <= i_rx_p_data;
          r_wr_en   <= 1'b1;
          r_state   <= StAluB;
        end
        StAluB: if (i_rx_d_valid) begin
          r_addr    <= ADDR_W'(1);
          r_wr_data <= i_rx_p_data;
          r_wr_en   <= 1'b1;
          r_state   <= StAluFun;
        end
        StAluFun: if (i_rx_d_valid) begin
          r_alu_fun <= i_rx_p_data[FUN_W-1:0];
          r_clk_en  <= 1'b1;
          r_state   <= StAluGate;
        end
        StAluGate: begin
          r_alu_en <= 1'b1;
          r_state  <= StAluWait;
        end
        StAluWait: if (i_alu_valid) begin
          r_res        <= i_alu_out;
          r_bytes_left <= BL_W'(RES_BYTES);
          r_push_pend  <= 1'b1;
          r_clk_en     <= 1'b0;
          r_state      <= StPush;
        end
        StBwAddr, StBrAddr: if (i_rx_d_valid) begin
          r_ptr   <= i_rx_p_data[ADDR_W-1:0];
          r_state <= (r_state == StBwAddr) ? StBwCnt : StBrCnt;
        end
        StBwCnt: if (i_rx_d_valid) begin
          r_cnt   <= i_rx_p_data;
          r_state <= (i_rx_p_data == '0) ? StIdle : StBwData;
        end
        StBwData: if (i_rx_d_valid) begin
          r_addr    <= r_ptr;
          r_ptr     <= r_ptr + ADDR_W'(1);
          r_wr_data <= i_rx_p_data;
          r_wr_en   <= 1'b1;
          r_cnt     <= r_cnt - DATA_W'(1);
          if (r_cnt == DATA_W'(1)) r_state <= StIdle;
        end
        StBrCnt: if (i_rx_d_valid) begin
          r_cnt <= i_rx_p_data;
          if (i_rx_p_data == '0) begin
            r_state <= StIdle;
          end else begin
            r_addr  <= r_ptr;
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_rd_en <= 1'b1;
            r_state <= StBrIssue;
          end
        end
        StPush: if (w_push_done) begin
          // Low byte of r_res is always the pending FIFO word.
          if (r_bytes_left > BL_W'(1)) begin
            r_res        <= r_res >> DATA_W;
            r_bytes_left <= r_bytes_left - BL_W'(1);
          end else begin
            r_push_pend <= 1'b0;
            if (r_cnt > DATA_W'(1)) begin
              r_cnt   <= r_cnt - DATA_W'(1);
              r_addr  <= r_ptr;
              r_ptr   <= r_ptr + ADDR_W'(1);
              r_rd_en <= 1'b1;
              r_state <= StBrIssue;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_alu_en      = r_alu_en;
  assign o_clk_en      = r_clk_en;
  assign o_wr_en       = r_wr_en;
  assign o_rd_en       = r_rd_en;
  assign o_addr        = r_addr;
  assign o_wr_data     = r_wr_data;
  assign o_alu_fun     = r_alu_fun;
  assign o_err         = r_err;
  assign o_fifo_p_data = r_res[DATA_W-1:0];
  // Reset gate keeps a discarded push from leaking out in the reset cycle.
  assign o_wr_inc      = w_push_done & ~i_rst;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst: command frames with hand-computed register,
// ALU, FIFO and error responses.
module tb_sys_ctrl_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_v = 1'b0;
  logic [7:0]  rx_d = '0;
  logic        rd_v = 1'b0;
  logic [7:0]  rd_d = '0;
  logic        alu_v = 1'b0;
  logic [15:0] alu_o = '0;
  logic        full = 1'b0;
  logic        alu_en, clk_en, wr_en, rd_en, wr_inc, err;
  logic [3:0]  addr, alu_fun;
  logic [7:0]  wr_data, fifo_d;
  logic [29:0] all_out;

  int vecs = 0;
  int errs = 0;
  int mon_errs = 0;
  int n_push = 0;

  sys_ctrl_burst #(.DATA_W(8), .ADDR_W(4), .FUN_W(4), .RES_W(16)) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_d_valid  (rx_v),
    .i_rx_p_data   (rx_d),
    .i_rd_d_valid  (rd_v),
    .i_rd_data     (rd_d),
    .i_alu_valid   (alu_v),
    .i_alu_out     (alu_o),
    .i_full        (full),
    .o_alu_en      (alu_en),
    .o_clk_en      (clk_en),
    .o_wr_en       (wr_en),
    .o_rd_en       (rd_en),
    .o_addr        (addr),
    .o_wr_data     (wr_data),
    .o_alu_fun     (alu_fun),
    .o_wr_inc      (wr_inc),
    .o_fifo_p_data (fifo_d),
    .o_err         (err)
  );

  assign all_out = {alu_en, clk_en, wr_en, rd_en, addr, wr_data, alu_fun, wr_inc, fifo_d, err};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && wr_inc) n_push++;
    if (wr_inc && full) begin
      mon_errs++;
      $display("FAIL wr_inc_while_full: wr_inc=%b full=%b", wr_inc, full);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_v = 1'b1;
    rx_d = b;
    tick();
    rx_v = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++;
    if (all_out !== 30'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want %h", all_out, 30'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    send(8'hAA); send(8'h05); send(8'h3C);
    vecs++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h5, 8'h3C}) begin
      errs++;
      $display("FAIL single_write: got %h want %h", {wr_en, addr, wr_data}, {1'b1, 4'h5, 8'h3C});
    end
    tick();
    vecs++;
    if (wr_en !== 1'b0) begin
      errs++;
      $display("FAIL write_pulse_end: got %b want 0", wr_en);
    end
    send(8'hBB); send(8'h05);
    vecs++;
    if ({rd_en, addr} !== {1'b1, 4'h5}) begin
      errs++;
      $display("FAIL single_read_issue: got %h want %h", {rd_en, addr}, {1'b1, 4'h5});
    end
    rd_v = 1'b1; rd_d = 8'h3C;
    tick();
    rd_v = 1'b0;
    vecs++;
    if ({wr_inc, fifo_d, rd_en} !== {1'b1, 8'h3C, 1'b0}) begin
      errs++;
      $display("FAIL single_read_push: got %h want %h", {wr_inc, fifo_d, rd_en}, {1'b1, 8'h3C, 1'b0});
    end
    tick();
    vecs++;
    if (wr_inc !== 1'b0) begin
      errs++;
      $display("FAIL single_read_one_push: got %b want 0", wr_inc);
    end
  endtask

  task automatic test_alu_operands();
    send(8'hCC); send(8'h07);
    vecs++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h0, 8'h07}) begin
      errs++;
      $display("FAIL alu_opa_write: got %h want %h", {wr_en, addr, wr_data}, {1'b1, 4'h0, 8'h07});
    end
    send(8'h03);
    vecs++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h1, 8'h03}) begin
      errs++;
      $display("FAIL alu_opb_write: got %h want %h", {wr_en, addr, wr_data}, {1'b1, 4'h1, 8'h03});
    end
    send(8'h00);
    vecs++;
    if ({clk_en, alu_en, alu_fun} !== {2'b10, 4'h0}) begin
      errs++;
      $display("FAIL alu_gate_first: got %h want %h", {clk_en, alu_en, alu_fun}, {2'b10, 4'h0});
    end
    tick();
    vecs++;
    if ({clk_en, alu_en} !== 2'b11) begin
      errs++;
      $display("FAIL alu_start: got %b want 11", {clk_en, alu_en});
    end
    alu_v = 1'b1; alu_o = 16'h000A;
    tick();
    alu_v = 1'b0;
    vecs++;
    if ({clk_en, alu_en, wr_inc, fifo_d} !== {3'b001, 8'h0A}) begin
      errs++;
      $display("FAIL alu_push_lsb: got %h want %h", {clk_en, alu_en, wr_inc, fifo_d}, {3'b001, 8'h0A});
    end
    tick();
    vecs++;
    if ({wr_inc, fifo_d} !== {1'b1, 8'h00}) begin
      errs++;
      $display("FAIL alu_push_msb: got %h want %h", {wr_inc, fifo_d}, {1'b1, 8'h00});
    end
    tick();
    vecs++;
    if ({wr_inc, clk_en} !== 2'b00) begin
      errs++;
      $display("FAIL alu_push_end: got %b want 00", {wr_inc, clk_en});
    end
  endtask

  task automatic test_burst_write_wrap();
    logic [3:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a[0] = 4'hF; exp_a[1] = 4'h0; exp_a[2] = 4'h1;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    send(8'hEE); send(8'h0F); send(8'h03);
    for (int i = 0; i < 3; i++) begin
      send(exp_d[i]);
      vecs++;
      if ({wr_en, addr, wr_data} !== {1'b1, exp_a[i], exp_d[i]}) begin
        errs++;
        $display("FAIL burst_write_%0d: got %h want %h", i, {wr_en, addr, wr_data},
                 {1'b1, exp_a[i], exp_d[i]});
      end
    end
    tick();
    vecs++;
    if (wr_en !== 1'b0) begin
      errs++;
      $display("FAIL burst_write_end: got %b want 0", wr_en);
    end
  endtask

  task automatic test_burst_read_backpressure();
    int p0;
    p0 = n_push;
    send(8'hEF); send(8'h02); send(8'h03);
    vecs++;
    if ({rd_en, addr} !== {1'b1, 4'h2}) begin
      errs++;
      $display("FAIL burst_read_issue0: got %h want %h", {rd_en, addr}, {1'b1, 4'h2});
    end
    rd_v = 1'b1; rd_d = 8'hA0; full = 1'b1;
    tick();
    rd_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if ({wr_inc, fifo_d} !== {1'b0, 8'hA0}) begin
        errs++;
        $display("FAIL burst_read_hold_%0d: got %h want %h", i, {wr_inc, fifo_d}, {1'b0, 8'hA0});
      end
      if (i < 4) tick();
    end
    full = 1'b0;
    #1;
    vecs++;
    if ({wr_inc, fifo_d} !== {1'b1, 8'hA0}) begin
      errs++;
      $display("FAIL burst_read_release: got %h want %h", {wr_inc, fifo_d}, {1'b1, 8'hA0});
    end
    tick();
    vecs++;
    if ({rd_en, addr, wr_inc} !== {1'b1, 4'h3, 1'b0}) begin
      errs++;
      $display("FAIL burst_read_issue1: got %h want %h", {rd_en, addr, wr_inc}, {1'b1, 4'h3, 1'b0});
    end
    rd_v = 1'b1; rd_d = 8'hB1;
    tick();
    rd_v = 1'b0;
    vecs++;
    if ({wr_inc, fifo_d, rd_en} !== {1'b1, 8'hB1, 1'b0}) begin
      errs++;
      $display("FAIL burst_read_push1: got %h want %h", {wr_inc, fifo_d, rd_en}, {1'b1, 8'hB1, 1'b0});
    end
    tick();
    vecs++;
    if ({rd_en, addr} !== {1'b1, 4'h4}) begin
      errs++;
      $display("FAIL burst_read_issue2: got %h want %h", {rd_en, addr}, {1'b1, 4'h4});
    end
    rd_v = 1'b1; rd_d = 8'hC2;
    tick();
    rd_v = 1'b0;
    vecs++;
    if ({wr_inc, fifo_d} !== {1'b1, 8'hC2}) begin
      errs++;
      $display("FAIL burst_read_push2: got %h want %h", {wr_inc, fifo_d}, {1'b1, 8'hC2});
    end
    tick();
    vecs++;
    if ({wr_inc, rd_en, n_push - p0} !== {2'b00, 32'd3}) begin
      errs++;
      $display("FAIL burst_read_total: wr_inc/rd_en=%b pushes=%0d want 00 and 3",
               {wr_inc, rd_en}, n_push - p0);
    end
  endtask

  task automatic test_errors();
    send(8'h55);
    vecs++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL bad_opcode_err: got %b want 1", err);
    end
    tick();
    vecs++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL bad_opcode_pulse: got %b want 0", err);
    end
    send(8'hDD); send(8'h05);
    tick();
    tick();
    send(8'h77);
    vecs++;
    if ({err, clk_en, alu_fun} !== {2'b11, 4'h5}) begin
      errs++;
      $display("FAIL dropped_byte_err: got %h want %h", {err, clk_en, alu_fun}, {2'b11, 4'h5});
    end
    alu_v = 1'b1; alu_o = 16'hBEEF;
    tick();
    alu_v = 1'b0;
    vecs++;
    if ({err, clk_en, wr_inc, fifo_d} !== {3'b001, 8'hEF}) begin
      errs++;
      $display("FAIL alu_fun_push_lsb: got %h want %h", {err, clk_en, wr_inc, fifo_d}, {3'b001, 8'hEF});
    end
    tick();
    vecs++;
    if ({wr_inc, fifo_d} !== {1'b1, 8'hBE}) begin
      errs++;
      $display("FAIL alu_fun_push_msb: got %h want %h", {wr_inc, fifo_d}, {1'b1, 8'hBE});
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    send(8'hEE); send(8'h00); send(8'h04); send(8'h11);
    vecs++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h0, 8'h11}) begin
      errs++;
      $display("FAIL mid_burst_write: got %h want %h", {wr_en, addr, wr_data}, {1'b1, 4'h0, 8'h11});
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (all_out !== 30'd0) begin
      errs++;
      $display("FAIL mid_burst_reset: got %h want %h", all_out, 30'd0);
    end
    rst = 1'b0;
    send(8'hAA); send(8'h01); send(8'hFF);
    vecs++;
    if ({wr_en, addr, wr_data, err} !== {1'b1, 4'h1, 8'hFF, 1'b0}) begin
      errs++;
      $display("FAIL post_reset_write: got %h want %h", {wr_en, addr, wr_data, err},
               {1'b1, 4'h1, 8'hFF, 1'b0});
    end
    tick();
  endtask

  task automatic test_reset_pending_push();
    send(8'hBB); send(8'h03);
    rd_v = 1'b1; rd_d = 8'h66; full = 1'b1;
    tick();
    rd_v = 1'b0;
    vecs++;
    if ({wr_inc, fifo_d} !== {1'b0, 8'h66}) begin
      errs++;
      $display("FAIL pend_held: got %h want %h", {wr_inc, fifo_d}, {1'b0, 8'h66});
    end
    rst = 1'b1; full = 1'b0;
    #1;
    vecs++;
    if (wr_inc !== 1'b0) begin
      errs++;
      $display("FAIL reset_cycle_wr_inc: got %b want 0", wr_inc);
    end
    tick();
    rst = 1'b0;
    vecs++;
    if (all_out !== 30'd0) begin
      errs++;
      $display("FAIL pend_discarded: got %h want %h", all_out, 30'd0);
    end
    tick();
    vecs++;
    if (wr_inc !== 1'b0) begin
      errs++;
      $display("FAIL pend_stays_gone: got %b want 0", wr_inc);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alu_operands();
    test_burst_write_wrap();
    test_burst_read_backpressure();
    test_errors();
    test_reset_mid_burst();
    test_reset_pending_push();
    errs = errs + mon_errs;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_burst.md
# sys_ctrl_burst

Parametrised command controller for the ALU/UART system, running in the reference clock domain between the receive-side data synchroniser and the register file, ALU, clock gate and TX async FIFO. It decodes command frames from the synchronised RX byte stream, sequences register-file and ALU transactions, and serialises results into FIFO pushes. It generalises the single-byte controller: data/address/function widths are parameters, multi-byte ALU results are supported, and burst register write/read commands are added. FIFO backpressure is honoured, and error signalling covers unknown opcodes and dropped bytes.

## Interface
- DATA_W, 8: RX byte, register and FIFO word width.
- ADDR_W, 4: register-file address width; addresses wrap modulo 2^ADDR_W.
- FUN_W, 4: ALU function code width; taken from the low FUN_W bits of the function byte.
- RES_W, 16: ALU result width; must be a multiple of DATA_W. RES_BYTES = RES_W/DATA_W.

Ports:
- clk  in  1  reference clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_d_valid  in  1  one-cycle strobe; rx_p_data valid.
- rx_p_data  in  DATA_W  synchronised received byte.
- rd_d_valid  in  1  register-file read data valid.
- rd_data  in  DATA_W  register-file read data.
- alu_valid  in  1  ALU result valid.
- alu_out  in  RES_W  ALU result.
- full  in  1  TX FIFO full.
- alu_en  out  1  one-cycle ALU start.
- clk_en  out  1  ALU clock-gate enable.
- wr_en  out  1  register write strobe.
- rd_en  out  1  register read strobe.
- addr  out  ADDR_W  register address.
- wr_data  out  DATA_W  register write data.
- alu_fun  out  FUN_W  ALU function.
- wr_inc  out  1  FIFO push; combinational = push_pend & !full.
- fifo_p_data  out  DATA_W  FIFO write data; registered.
- err  out  1  one-cycle error pulse.

## Operation
- Opcodes, first byte in IDLE:
  - 0xAA: write; frames addr, data.
  - 0xBB: read; frame addr.
  - 0xCC: ALU with operands; frames A, B, fun.
  - 0xDD: ALU without operands; frame fun.
  - 0xEE: burst write; frames addr, N, then N data bytes.
  - 0xEF: burst read; frames addr, N.
- Any other opcode in IDLE: err pulse; stay in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_GATE, ALU_WAIT, BW_ADDR, BW_CNT, BW_DATA, BR_ADDR, BR_CNT, BR_ISSUE, BR_WAIT, PUSH.
- Write and burst-write data: wr_en with addr/wr_data. Burst increments addr after each write, with wrap-around.
- 0xCC operands: A is written to address 0, B to address 1.
- Read (single or burst): rd_en pulse, then wait for rd_d_valid. Captured data goes to PUSH; a burst returns to BR_ISSUE with addr+1 until N bytes are pushed.
- ALU: on the fun byte, latch alu_fun and set clk_en. The next cycle is ALU_GATE, then alu_en pulses. In ALU_WAIT, alu_out is latched on alu_valid. PUSH then emits RES_BYTES bytes, LSB first, and clk_en clears on entry to PUSH.
- PUSH: one byte is pending at a time. While full=1 the byte is held, with fifo_p_data stable. The byte completes in the cycle wr_inc=1.
- N=0 on a burst command: return to IDLE after the count byte, with no register access.
- An rx_d_valid arriving in a non-accepting state (RD_WAIT, ALU_*WAIT/GATE, BR_ISSUE/WAIT, PUSH) drops the byte and pulses err. The FSM is unaffected.
- No timeouts. A missing rd_d_valid or alu_valid stalls the FSM until reset.

## Timing
- Reset values: all outputs 0, addr=0, alu_fun=0, state IDLE, push_pend=0.
- A byte strobed in cycle T gives its registered response (wr_en, rd_en, clk_en) in T+1.
- ALU sequence (T = fun byte): clk_en=1 from T+1, alu_en=1 in T+2 only.
- ALU result: alu_valid in cycle V produces the first push attempt in V+1, with clk_en=0 from V+1.
- Read: rd_d_valid in cycle R produces the push attempt in R+1.
- Consecutive pushes: with full=0 throughout, one per cycle.
- Burst read issue: the next rd_en follows one cycle after the preceding push completes.
- Reset asserted mid-operation: takes effect at the next edge. A pending push is discarded, wr_inc is 0 in the reset cycle, and partial frames are lost.
- wr_inc is never 1 while full=1.

## Test plan
- Single write then read: AA 05 3C, then BB 05 → wr_en @addr 5 data 0x3C. After rd_d_valid, one push of 0x3C.
- ALU with operands: CC 07 03 00 (add), alu_out=0x000A → writes addr0=0x07 and addr1=0x03. clk_en rises one cycle before alu_en; pushes are 0x0A then 0x00, and clk_en clears.
- Burst write wrap: EE 0F 03 11 22 33 → wr_en at addresses 0xF, 0x0, 0x1 with data 0x11, 0x22, 0x33.
- Burst read with backpressure: EF 02 03 with full=1 for 5 cycles during the first push → wr_inc stays 0 and fifo_p_data is stable. Three pushes total, in address order 2, 3, 4.
- Errors: opcode 0x55 → one err pulse, then IDLE. A byte strobed during ALU_WAIT → err pulse, and the result is still pushed correctly.
- Reset mid-burst: rst during BW_DATA after 1 of 4 bytes → all outputs 0 next cycle. A subsequent AA 01 FF completes normally.
